// File: rtl/custom_inputs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | custom_inputs_pkg : register map and defaults for the custom_inputs IP   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package custom_inputs_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_EDGE = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_RAW  = 2'd3
  } reg_addr_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int AVS_DATA_W              = 32;

endpackage
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_debouncer : 2-flop synchronizer plus stable-count debouncer for    |
// | one pin; CUSTOM_INPUTS_DEBOUNCE_EN selects the counter build.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module input_debouncer
  import custom_inputs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic sync,
  output logic stable,
  output logic chg
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("input_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  logic meta_q;
  logic sync_q;
  logic stable_q;
  logic stable_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
    end
  end

`ifdef CUSTOM_INPUTS_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any sample matching the accepted level restarts the stability window.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    chg      = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
      chg      = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
`else
  always_comb begin
    stable_d = sync_q;
    chg      = sync_q ^ stable_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
    end
  end
`endif

  assign sync   = sync_q;
  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/custom_inputs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | custom_inputs : Avalon-MM push-button/switch reader with edge capture    |
// | and maskable level irq. Build macro: CUSTOM_INPUTS_DEBOUNCE_EN.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module custom_inputs
  import custom_inputs_pkg::*;
#(
  parameter int NUM_INPUTS      = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            avs_s0_address,
  input  logic                  avs_s0_read,
  output logic [AVS_DATA_W-1:0] avs_s0_readdata,
  input  logic                  avs_s0_write,
  input  logic [AVS_DATA_W-1:0] avs_s0_writedata,
  input  logic [NUM_INPUTS-1:0] ins_raw,
  output logic                  irq
);

  logic [NUM_INPUTS-1:0] sync_w;
  logic [NUM_INPUTS-1:0] stable_w;
  logic [NUM_INPUTS-1:0] chg_w;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_inputs
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (ins_raw[i]),
      .sync   (sync_w[i]),
      .stable (stable_w[i]),
      .chg    (chg_w[i])
    );
  end

  logic [NUM_INPUTS-1:0] w1c;
  logic [NUM_INPUTS-1:0] edge_d;
  logic [NUM_INPUTS-1:0] edge_q;
  logic [NUM_INPUTS-1:0] mask_d;
  logic [NUM_INPUTS-1:0] mask_q;
  logic                  irq_d;
  logic                  irq_q;
  logic [AVS_DATA_W-1:0] readdata_d;
  logic [AVS_DATA_W-1:0] readdata_q;

  // Only the low NUM_INPUTS bits of a write carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^avs_s0_writedata;

  always_comb begin
    w1c    = '0;
    mask_d = mask_q;
    if (avs_s0_write) begin
      case (reg_addr_e'(avs_s0_address))
        ADDR_EDGE: w1c    = avs_s0_writedata[NUM_INPUTS-1:0];
        ADDR_MASK: mask_d = avs_s0_writedata[NUM_INPUTS-1:0];
        default:   ;
      endcase
    end
  end

  // A change landing on a bit being cleared keeps the bit set.
  always_comb begin
    edge_d = (edge_q & ~w1c) | chg_w;
    irq_d  = |(edge_q & mask_q);
  end

  always_comb begin
    readdata_d = readdata_q;
    if (avs_s0_read) begin
      readdata_d = '0;
      case (reg_addr_e'(avs_s0_address))
        ADDR_DATA: readdata_d[NUM_INPUTS-1:0] = stable_w;
        ADDR_EDGE: readdata_d[NUM_INPUTS-1:0] = edge_q;
        ADDR_MASK: readdata_d[NUM_INPUTS-1:0] = mask_q;
        ADDR_RAW:  readdata_d[NUM_INPUTS-1:0] = sync_w;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_s0_readdata = readdata_q;
  assign irq             = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_custom_inputs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_custom_inputs : directed scoreboard bench for custom_inputs           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_custom_inputs;
  import custom_inputs_pkg::*;

  localparam int NUM_INPUTS = 4;
  localparam int DEB        = 4;
`ifdef CUSTOM_INPUTS_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [1:0]            addr;
  logic                  rd;
  logic                  wr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic [NUM_INPUTS-1:0] ins_raw;
  logic                  irq;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  always #5 clk = ~clk;

  custom_inputs #(
    .NUM_INPUTS     (NUM_INPUTS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_s0_address  (addr),
    .avs_s0_read     (rd),
    .avs_s0_readdata (rdata),
    .avs_s0_write    (wr),
    .avs_s0_writedata(wdata),
    .ins_raw         (ins_raw),
    .irq             (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] expv, input string tag);
    sb_item_t it;
    it.tag = tag;
    it.exp = expv;
    sb_q.push_back(it);
    addr = a;
    rd   = 1'b1;
    tick();
    rd = 1'b0;
    it = sb_q.pop_front();
    check(it.tag, rdata, it.exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  logic [31:0] hold_exp;

  initial begin
    reset_n = 1'b0;
    addr    = '0;
    rd      = 1'b0;
    wr      = 1'b0;
    wdata   = '0;
    ins_raw = '0;
    repeat (3) tick();
    check("rst_readdata", rdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();

    bus_read(ADDR_DATA, 32'h0, "rst_data");
    bus_read(ADDR_EDGE, 32'h0, "rst_edge");
    bus_read(ADDR_MASK, 32'h0, "rst_mask");
    bus_read(ADDR_RAW,  32'h0, "rst_raw");
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    bus_read(ADDR_DATA, 32'h0, "data_ro");
    bus_write(ADDR_MASK, 32'hFFFF_FFFF);
    bus_read(ADDR_MASK, 32'h0000_000F, "mask_width");
    bus_write(ADDR_MASK, 32'h0);

    // Clean press on bit0: exact pin-to-DATA latency.
    ins_raw = 4'b0001;
    repeat (LAT - 1) tick();
    bus_read(ADDR_DATA, 32'h0, "press_data_early");
    bus_read(ADDR_DATA, 32'h1, "press_data");
    bus_read(ADDR_EDGE, 32'h1, "press_edge");
    bus_read(ADDR_RAW,  32'h1, "press_raw");
    check("press_irq_masked", {31'd0, irq}, 32'h0);
    bus_write(ADDR_EDGE, 32'h1);
    bus_read(ADDR_EDGE, 32'h0, "w1c_clear");

    // Release: falling change is captured too.
    ins_raw = 4'b0000;
    repeat (LAT + 2) tick();
    bus_read(ADDR_DATA, 32'h0, "release_data");
    bus_read(ADDR_EDGE, 32'h1, "release_edge");
    bus_write(ADDR_EDGE, 32'h1);

    // Bounce: short highs never qualify; the final hold does.
    ins_raw = 4'b0001; repeat (2) tick();
    ins_raw = 4'b0000; tick();
    ins_raw = 4'b0001; repeat (2) tick();
    ins_raw = 4'b0000; tick();
    ins_raw = 4'b0001;
    repeat (LAT - 1) tick();
    bus_read(ADDR_DATA, 32'h0, "bounce_data_early");
    bus_read(ADDR_DATA, 32'h1, "bounce_data");
    bus_read(ADDR_EDGE, 32'h1, "bounce_edge");

    // Interrupt path and W1C.
    ins_raw = 4'b0000;
    repeat (LAT + 2) tick();
    bus_write(ADDR_EDGE, 32'hF);
    bus_write(ADDR_MASK, 32'h1);
    bus_read(ADDR_MASK, 32'h1, "mask_rw");
    check("irq_idle", {31'd0, irq}, 32'h0);
    ins_raw = 4'b0001;
    repeat (LAT) tick();
    check("irq_same_cycle_as_edge", {31'd0, irq}, 32'h0);
    tick();
    check("irq_rise", {31'd0, irq}, 32'h1);
    bus_write(ADDR_EDGE, 32'h2);
    bus_read(ADDR_EDGE, 32'h1, "w1c_other_bit");
    check("irq_kept", {31'd0, irq}, 32'h1);
    bus_write(ADDR_EDGE, 32'h1);
    check("irq_lag", {31'd0, irq}, 32'h1);
    tick();
    check("irq_fall", {31'd0, irq}, 32'h0);

    // Set wins over a same-cycle W1C on bit2.
    ins_raw = 4'b0101;
    repeat (LAT - 1) tick();
    bus_write(ADDR_EDGE, 32'h4);
    bus_read(ADDR_EDGE, 32'h4, "set_wins");
    check("irq_bit2_masked", {31'd0, irq}, 32'h0);

    // Reset mid-debounce on bit3.
    ins_raw = 4'b0000;
    repeat (LAT + 2) tick();
    bus_write(ADDR_EDGE, 32'hF);
    bus_read(ADDR_MASK, 32'h1, "pre_reset_mask");
    ins_raw = 4'b1000;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", rdata, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    bus_read(ADDR_EDGE, 32'h0, "postrst_edge");
    bus_read(ADDR_MASK, 32'h0, "postrst_mask");
    repeat (LAT - 3) tick();
    bus_read(ADDR_DATA, 32'h0, "postrst_data_early");
    bus_read(ADDR_DATA, 32'h8, "postrst_data");
    bus_read(ADDR_EDGE, 32'h8, "postrst_edge_set");
    check("postrst_irq", {31'd0, irq}, 32'h0);

    // RAW latency and old DATA inside the debounce window.
    ins_raw = 4'b1010;
    tick();
    bus_read(ADDR_RAW, 32'h8, "raw_early");
    bus_read(ADDR_RAW, 32'hA, "raw");
    hold_exp = (LAT > 3) ? 32'h8 : 32'hA;
    bus_read(ADDR_DATA, hold_exp, "data_in_window");
    repeat (3) tick();
    check("readdata_hold", rdata, hold_exp);
    repeat (LAT + 2) tick();
    bus_read(ADDR_DATA, 32'hA, "final_data");
    bus_read(ADDR_EDGE, 32'hA, "final_edge");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
